// File: rtl/fb_scanout_arbiter_pkg.sv
// Shared video package for the framebuffer path and the HDMI interface.
// It holds the default framebuffer geometry (640x480, one RGB332 byte per
// pixel), the pixel width and the arbitration grant encoding.
package fb_scanout_arbiter_pkg;

  localparam int unsigned VID_FB_WORDS = 307200;
  localparam int unsigned VID_ADDR_W   = 19;
  localparam int unsigned PIX_W        = 8;

  typedef logic [PIX_W-1:0] rgb332_t;

  // Owner of the single RAM port in a given cycle
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_SCAN = 2'd1,
    GNT_CPU  = 2'd2
  } grant_e;

endpackage

// File: rtl/fb_scanout_arbiter_sync_fifo.sv
// sync_fifo: single-clock FIFO that buffers prefetched scanout pixels.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   clear_i     - drops every entry at the next edge (wins over push/pop)
//   push_i      - write wdata_i (ignored when full)
//   pop_i       - drop the head entry (ignored when empty)
//   rdata_o     - current head entry, valid only when empty_o is low
//   count_o     - number of stored entries
//   empty_o     - no entries stored
module sync_fifo
  import fb_scanout_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = PIX_W,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // pointers wrap naturally; a simultaneous push and pop leaves count alone.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// fb_scanout_arbiter: shares one single-port framebuffer RAM (read latency 1)
// between display scanout prefetch and CPU accesses.
// Ports:
//   clk, rst_n                 - pixel clock, synchronous active-low reset
//   frame_start                - restart scanout at address 0, flush prefetch
//   pix_pop                    - display consumes the head pixel
//   pix_data, underflow        - head pixel (0 when empty), sticky pop-on-empty
//   cpu_valid/we/addr/wdata    - CPU request, held until cpu_ready
//   cpu_ready                  - CPU request granted this cycle
//   cpu_rvalid, cpu_rdata      - CPU read return, one cycle after the grant
//   mem_en/we/addr/wdata       - RAM port, driven from this cycle's grant
//   mem_rdata                  - RAM read data, one cycle after mem_en
module fb_scanout_arbiter
  import fb_scanout_arbiter_pkg::*;
#(
  parameter int unsigned FB_WORDS   = VID_FB_WORDS,
  parameter int unsigned ADDR_W     = VID_ADDR_W,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LOW_WATER  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [PIX_W-1:0]  pix_data,
  output logic              underflow,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [PIX_W-1:0]  cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [PIX_W-1:0]  cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  // fill_addr has one spare bit so it can rest at FB_WORDS after the frame
  logic [ADDR_W:0] fill_addr_q, fill_addr_d;
  logic            inflight_q, inflight_d;
  logic            underflow_q, underflow_d;
  logic            cpu_rd_q, cpu_rd_d;

  grant_e          grant;
  logic            scan_ok;
  logic [CNT_W:0]  occ;
  logic [CNT_W-1:0] fifo_count;
  logic            fifo_empty;
  rgb332_t         fifo_rdata;
  logic            fifo_push;
  logic            fifo_pop;

  // Occupancy counts the read already on its way so the FIFO can never overflow
  assign occ = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q);

  // Scanout is held off while in reset and during the frame_start cycle,
  // because fill_addr is being rewound on that edge.
  assign scan_ok = rst_n && !frame_start && (fill_addr_q < (ADDR_W+1)'(FB_WORDS));

  // Arbitration: starving scanout first, then the CPU, then opportunistic
  // prefetch to top the FIFO up.
  always_comb begin
    grant = GNT_IDLE;
    if (scan_ok && (occ < (CNT_W+1)'(LOW_WATER))) begin
      grant = GNT_SCAN;
    end else if (rst_n && cpu_valid) begin
      grant = GNT_CPU;
    end else if (scan_ok && (occ < (CNT_W+1)'(FIFO_DEPTH))) begin
      grant = GNT_SCAN;
    end
  end

  // RAM port and handshake outputs follow the grant combinationally
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = fill_addr_q[ADDR_W-1:0];
    mem_wdata = '0;
    cpu_ready = 1'b0;
    unique case (grant)
      GNT_SCAN: begin
        mem_en = 1'b1;
      end
      GNT_CPU: begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ready = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // frame_start discards the returning scanout byte and ignores a pop, but a
  // CPU read return is never cancelled by it.
  assign fifo_push = inflight_q && !frame_start;
  assign fifo_pop  = pix_pop && !frame_start;

  // Next-state for the scanout pointer, in-flight flags and sticky underflow
  always_comb begin
    fill_addr_d = fill_addr_q;
    inflight_d  = (grant == GNT_SCAN);
    cpu_rd_d    = (grant == GNT_CPU) && !cpu_we;
    underflow_d = underflow_q;
    if (frame_start) begin
      fill_addr_d = '0;
      underflow_d = 1'b0;
    end else begin
      if (grant == GNT_SCAN) fill_addr_d = fill_addr_q + 1'b1;
      if (pix_pop && fifo_empty) underflow_d = 1'b1;
    end
  end

  // Scanout stays idle after reset until the first frame_start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_addr_q <= (ADDR_W+1)'(FB_WORDS);
      inflight_q  <= 1'b0;
      cpu_rd_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      fill_addr_q <= fill_addr_d;
      inflight_q  <= inflight_d;
      cpu_rd_q    <= cpu_rd_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (frame_start),
    .push_i  (fifo_push),
    .wdata_i (mem_rdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign pix_data   = fifo_empty ? '0 : fifo_rdata;
  assign underflow  = underflow_q;
  assign cpu_rvalid = cpu_rd_q;
  assign cpu_rdata  = cpu_rd_q ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Self-checking bench for fb_scanout_arbiter with a small framebuffer.
// A behavioural single-port RAM (latency 1) sits on the mem_* port. Expected
// pixels are queued from the bench's own image at each frame_start and
// compared as the display pops; expected CPU read data is queued when a
// read is requested and compared when cpu_rvalid is due.
module tb_fb_scanout_arbiter;

  localparam int FBW = 1024;
  localparam int AW  = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          pix_pop = 1'b0;
  logic [7:0]    pix_data;
  logic          underflow;
  logic          cpu_valid = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = '0;
  logic          cpu_ready;
  logic          cpu_rvalid;
  logic [7:0]    cpu_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic          nxtRst = 1'b0;
  logic          nxtValid = 1'b0;
  logic          nxtWe = 1'b0;
  logic [AW-1:0] nxtAddr = '0;
  logic [7:0]    nxtWdata = '0;

  logic [7:0]    ramData [4096];
  bit            ramWritten [4096];
  logic [7:0]    img [FBW];
  logic [7:0]    expPix [$];
  logic [7:0]    expRd [$];

  int checkCount = 0;
  int failCount = 0;
  int scanReads = 0;
  int badReads = 0;
  int wrAccepted = 0;
  bit popCheck = 0;
  bit rdDue = 0;
  bit found;

  fb_scanout_arbiter #(
    .FB_WORDS   (FBW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (16),
    .LOW_WATER  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pix_pop     (pix_pop),
    .pix_data    (pix_data),
    .underflow   (underflow),
    .cpu_valid   (cpu_valid),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ready   (cpu_ready),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // 10 ns pixel clock
  always #5 clk = ~clk;

  function automatic logic [7:0] pattern(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Single-port RAM model: unwritten locations return the preload pattern
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ramData[mem_addr[11:0]] <= mem_wdata;
        ramWritten[mem_addr[11:0]] <= 1'b1;
      end else begin
        mem_rdata <= ramWritten[mem_addr[11:0]] ? ramData[mem_addr[11:0]]
                                                 : pattern(int'(mem_addr[11:0]));
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then sample the settled
  // outputs 1 ns later and run the scoreboard checks for that cycle.
  task automatic applyStimulus(input logic fs, input logic pop);
    @(negedge clk);
    rst_n       = nxtRst;
    cpu_valid   = nxtValid;
    cpu_we      = nxtWe;
    cpu_addr    = nxtAddr;
    cpu_wdata   = nxtWdata;
    frame_start = fs;
    pix_pop     = pop;
    #1;
    if (rdDue) begin
      checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      if (expRd.size() > 0) checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(expRd.pop_front()));
      else checkOutput("cpu_rd_scoreboard", 32'd1, 32'(expRd.size()));
    end else begin
      checkOutput("cpu_rvalid_idle", 32'(cpu_rvalid), 32'd0);
    end
    rdDue = rst_n && cpu_valid && cpu_ready && !cpu_we;
    if (rst_n && mem_en && !mem_we && !cpu_ready) begin
      scanReads++;
      if (int'(mem_addr) >= FBW) badReads++;
    end
    if (fs) begin
      expPix.delete();
      for (int i = 0; i < FBW; i++) expPix.push_back(img[i]);
    end else if (pop && popCheck) begin
      if (expPix.size() > 0) checkOutput("pix_data", 32'(pix_data), 32'(expPix.pop_front()));
      else checkOutput("pix_scoreboard", 32'd1, 32'(expPix.size()));
    end
  endtask

  task automatic setCpu(input logic v, input logic we, input logic [AW-1:0] a,
                        input logic [7:0] d);
    nxtValid = v;
    nxtWe    = we;
    nxtAddr  = a;
    nxtWdata = d;
  endtask

  initial begin
    for (int i = 0; i < FBW; i++) img[i] = pattern(i);

    // Reset with a CPU request and a pop pending: nothing may move
    setCpu(1'b1, 1'b1, 19'h10, 8'h55);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    checkOutput("rst_underflow", 32'(underflow), 32'd0);
    checkOutput("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    checkOutput("rst_pix_data", 32'(pix_data), 32'd0);

    // Out of reset scanout waits for frame_start
    nxtRst = 1'b1;
    setCpu(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("idle_before_frame", 32'(mem_en), 32'd0);

    // Prefetch of addresses 0..15 on consecutive cycles, then idle when full
    applyStimulus(1'b1, 1'b0);
    checkOutput("fs_cycle_mem_en", 32'(mem_en), 32'd0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("fill_mem_en", 32'(mem_en), 32'd1);
      checkOutput("fill_mem_we", 32'(mem_we), 32'd0);
      checkOutput("fill_addr", 32'(mem_addr), 32'(i));
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("full_idle", 32'(mem_en), 32'd0);
    checkOutput("head_pixel", 32'(pix_data), 32'(img[0]));
    popCheck = 1;

    // Pop four while the CPU takes the port, leaving occ=12, then write 0xA5
    for (int k = 0; k < 4; k++) begin
      setCpu(1'b1, 1'b1, 19'(32'h800 + k), 8'(k));
      applyStimulus(1'b0, 1'b1);
      checkOutput("dummy_wr_ready", 32'(cpu_ready), 32'd1);
    end
    setCpu(1'b1, 1'b1, 19'h100, 8'hA5);
    applyStimulus(1'b0, 1'b0);
    checkOutput("wr_ready", 32'(cpu_ready), 32'd1);
    checkOutput("wr_mem_we", 32'(mem_we), 32'd1);
    checkOutput("wr_mem_addr", 32'(mem_addr), 32'h100);
    checkOutput("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
    img[12'h100] = 8'hA5;
    setCpu(1'b1, 1'b0, 19'h100, 8'h00);
    expRd.push_back(8'hA5);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rd_ready", 32'(cpu_ready), 32'd1);
    setCpu(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("ram_holds_a5", 32'(ramData[12'h100]), 32'hA5);

    // Low-water priority: drain to occ=7 under CPU writes, then a CPU read
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      setCpu(1'b1, 1'b1, 19'(32'h900 + k), 8'(k));
      applyStimulus(1'b0, 1'b1);
      checkOutput("blocker_ready", 32'(cpu_ready), 32'd1);
    end
    setCpu(1'b1, 1'b0, 19'h100, 8'h00);
    expRd.push_back(8'hA5);
    applyStimulus(1'b0, 1'b0);
    checkOutput("lowwater_cpu_wait", 32'(cpu_ready), 32'd0);
    checkOutput("lowwater_scan_en", 32'(mem_en & ~mem_we), 32'd1);
    checkOutput("lowwater_scan_addr", 32'(mem_addr), 32'd16);
    applyStimulus(1'b0, 1'b0);
    checkOutput("lowwater_cpu_grant", 32'(cpu_ready), 32'd1);
    checkOutput("lowwater_cpu_addr", 32'(mem_addr), 32'h100);
    setCpu(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0);

    // frame_start while the read of address 40 is in flight
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (mem_en && !mem_we && mem_addr == 19'd40) found = 1;
    end
    checkOutput("addr40_seen", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("fs_flush_mem_en", 32'(mem_en), 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("flush_empty", 32'(pix_data), 32'd0);
    checkOutput("restart_addr", 32'(mem_addr), 32'd0);
    checkOutput("restart_en", 32'(mem_en), 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("discard_inflight", 32'(pix_data), 32'd0);
    checkOutput("restart_addr1", 32'(mem_addr), 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("restart_head", 32'(pix_data), 32'(img[0]));
    checkOutput("fs_pop_ignored", 32'(underflow), 32'd0);

    // Underflow: pop from empty right after frame_start, cleared by the next
    popCheck = 0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("underflow_pre", 32'(underflow), 32'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("underflow_set", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("underflow_sticky", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("underflow_clear", 32'(underflow), 32'd0);

    // Full frame: one pop per cycle, CPU write offered every second cycle
    applyStimulus(1'b1, 1'b0);
    scanReads = 0;
    badReads = 0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
    popCheck = 1;
    for (int cyc = 0; cyc < FBW; cyc++) begin
      if (!nxtValid && (cyc % 2 == 0)) setCpu(1'b1, 1'b1, 19'(32'hA00 + (wrAccepted & 511)), 8'(cyc));
      applyStimulus(1'b0, 1'b1);
      if (cpu_valid && cpu_ready) begin
        wrAccepted++;
        nxtValid = 1'b0;
      end
    end
    setCpu(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("frame_no_underflow", 32'(underflow), 32'd0);
    checkOutput("frame_scan_reads", 32'(scanReads), 32'(FBW));
    checkOutput("frame_no_overrun", 32'(badReads), 32'd0);
    checkOutput("frame_pix_drained", 32'(expPix.size()), 32'd0);
    checkOutput("frame_cpu_served", 32'(wrAccepted > 0), 32'd1);
    checkOutput("frame_end_idle", 32'(mem_en), 32'd0);
    checkOutput("frame_end_empty", 32'(pix_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
